// File: rtl/boot_pkg.sv
// Shared constants and loader state encoding for the UART boot loader.
package boot_pkg;
    localparam logic [7:0]  BOOT_SYNC      = 8'hB0;
    localparam logic [31:0] BOOT_BASE_ADDR = 32'h0040_0000;

    typedef enum logic [2:0] {
        IDLE, COUNT, DATA, WRITE, CHECK, DONE, ERROR
    } boot_state_t;
endpackage

// File: rtl/uart_boot_loader_if.sv
// Memory_System write port driven by the boot loader.
interface uart_boot_loader_if;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;

    modport master (output mem_we_o, mem_addr_o, mem_wdata_o);
    modport slave  (input  mem_we_o, mem_addr_o, mem_wdata_o);
endinterface

// File: rtl/uart_boot_loader_rx.sv
// 8N1 UART receiver: synchronizer, falling-edge start detect, mid-bit sampling.
import boot_pkg::*;

module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_i,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);
    localparam int CW = $clog2(CLKS_PER_BIT) + 1;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t      st;
    logic [1:0]     sync;
    logic           rx_prev;
    logic [CW-1:0]  cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shift;
    logic           rx_s;

    assign rx_s = sync[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync       <= 2'b11;
            rx_prev    <= 1'b1;
            st         <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            sync       <= {sync[0], rx_i};
            rx_prev    <= rx_s;
            byte_valid <= 1'b0;
            case (st)
                // Edge, not level: a low stop bit must not look like a new start.
                RX_IDLE: begin
                    cnt <= '0;
                    if (rx_prev && !rx_s) st <= RX_START;
                end
                RX_START: begin
                    if (cnt == CW'(CLKS_PER_BIT / 2 - 1)) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        st      <= rx_s ? RX_IDLE : RX_DATA;
                    end else cnt <= cnt + 1'b1;
                end
                RX_DATA: begin
                    if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                        cnt     <= '0;
                        shift   <= {rx_s, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) st <= RX_STOP;
                    end else cnt <= cnt + 1'b1;
                end
                RX_STOP: begin
                    if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                        cnt        <= '0;
                        byte_valid <= 1'b1;
                        byte_data  <= shift;
                        frame_err  <= !rx_s;
                        st         <= RX_IDLE;
                    end else cnt <= cnt + 1'b1;
                end
                default: st <= RX_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/uart_boot_loader.sv
// Receives a framed program image over UART, writes it to memory from BASE_ADDR,
// and holds the core in reset until a checksum-valid image has landed.
import boot_pkg::*;

module uart_boot_loader #(
    parameter int          CLKS_PER_BIT = 434,
    parameter int          MEMORY_DEPTH = 64,
    parameter int          DATA_WIDTH   = 32,
    parameter logic [31:0] BASE_ADDR    = BOOT_BASE_ADDR
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx_i,
    uart_boot_loader_if.master  mem,
    output logic                cpu_reset_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o
);
    logic                  byte_valid, frame_err;
    logic [7:0]            byte_data;
    boot_state_t           state, state_n;
    logic [7:0]            n_words, idx, csum;
    logic [1:0]            byte_idx;
    logic [DATA_WIDTH-1:0] word, word_n;
    logic                  we_n, busy_n, done_n, cpu_reset_n, err_n;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .reset      (reset),
        .rx_i       (rx_i),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    // Little-endian: first byte shifts down to bits [7:0] after four bytes.
    assign word_n = {byte_data, word[DATA_WIDTH-1:8]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE:
                if (byte_valid && !frame_err && byte_data == BOOT_SYNC) state_n = COUNT;
            COUNT:
                if (byte_valid)
                    state_n = (frame_err || byte_data == 8'd0 || int'(byte_data) > MEMORY_DEPTH)
                              ? ERROR : DATA;
            DATA:
                if (byte_valid) begin
                    if (frame_err)              state_n = ERROR;
                    else if (byte_idx == 2'd3)  state_n = WRITE;
                end
            WRITE:
                state_n = (idx + 8'd1 == n_words) ? CHECK : DATA;
            CHECK:
                if (byte_valid) state_n = (frame_err || byte_data != csum) ? ERROR : DONE;
            ERROR:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up
    // with the state they describe.
    always_comb begin
        we_n        = (state_n == WRITE);
        busy_n      = (state_n inside {COUNT, DATA, WRITE, CHECK});
        done_n      = (state_n == DONE);
        cpu_reset_n = (state_n != DONE);
        err_n       = err_o;
        if (state_n == ERROR)                                   err_n = 1'b1;
        else if (state_n == COUNT && state inside {IDLE, DONE}) err_n = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem.mem_we_o    <= 1'b0;
            mem.mem_addr_o  <= BASE_ADDR;
            mem.mem_wdata_o <= '0;
            cpu_reset_o     <= 1'b1;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
            err_o           <= 1'b0;
            n_words         <= '0;
            idx             <= '0;
            csum            <= '0;
            byte_idx        <= '0;
            word            <= '0;
        end else begin
            mem.mem_we_o <= we_n;
            cpu_reset_o  <= cpu_reset_n;
            busy_o       <= busy_n;
            done_o       <= done_n;
            err_o        <= err_n;
            if (byte_valid) begin
                case (state)
                    COUNT: begin
                        n_words  <= byte_data;
                        csum     <= byte_data;
                        idx      <= '0;
                        byte_idx <= '0;
                    end
                    DATA: begin
                        word     <= word_n;
                        csum     <= csum ^ byte_data;
                        byte_idx <= byte_idx + 2'd1;
                    end
                    default: ;
                endcase
            end
            if (state == WRITE) idx <= idx + 8'd1;
            if (state_n == WRITE) begin
                mem.mem_addr_o  <= BASE_ADDR + {22'd0, idx, 2'b00};
                mem.mem_wdata_o <= word_n;
            end
        end
    end
endmodule

// File: tb/tb_uart_boot_loader.sv
// Randomized image stimulus against a byte-list reference model; a monitor
// scoreboards memory writes and status edges independently of the stimulus.
module tb_uart_boot_loader;
    import boot_pkg::*;

    localparam int          CPB   = 16;
    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0040_0000;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic rx = 1'b1;
    logic cpu_reset, busy, done, err;

    uart_boot_loader_if mem();

    uart_boot_loader #(
        .CLKS_PER_BIT (CPB),
        .MEMORY_DEPTH (DEPTH),
        .DATA_WIDTH   (32),
        .BASE_ADDR    (BASE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_i        (rx),
        .mem         (mem),
        .cpu_reset_o (cpu_reset),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    wr_t exp_q[$];
    int  tests = 0;
    int  fails = 0;
    int  cyc = 0;
    int  bv_cyc = -100;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Write scoreboard and latency monitor.
    initial begin
        logic we_prev = 1'b0;
        logic done_prev = 1'b0;
        wr_t  e;
        forever begin
            @(negedge clk);
            cyc++;
            if (dut.u_rx.byte_valid) bv_cyc = cyc;
            if (mem.mem_we_o) begin
                check("we_latency", 32'(cyc - bv_cyc), 32'd1);
                check("we_width", {31'd0, we_prev}, 32'd0);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: addr %h data %h, expected no write",
                             mem.mem_addr_o, mem.mem_wdata_o);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", mem.mem_addr_o, e.addr);
                    check("wr_data", mem.mem_wdata_o, e.data);
                end
            end
            if (done && !done_prev) begin
                check("done_latency", 32'(cyc - bv_cyc), 32'd1);
                check("cpu_reset_at_done", {31'd0, cpu_reset}, 32'd0);
            end
            we_prev   = mem.mem_we_o;
            done_prev = done;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        if (!stop) begin
            rx = 1'b1;
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_we"},    {31'd0, mem.mem_we_o}, 32'd0);
        check({tag, "_addr"},  mem.mem_addr_o, BASE);
        check({tag, "_wdata"}, mem.mem_wdata_o, 32'd0);
        check({tag, "_cpurst"}, {31'd0, cpu_reset}, 32'd1);
        check({tag, "_busy"},  {31'd0, busy}, 32'd0);
        check({tag, "_done"},  {31'd0, done}, 32'd0);
        check({tag, "_err"},   {31'd0, err}, 32'd0);
    endtask

    function automatic bq_t make_image(input logic [31:0] words[$]);
        bq_t        q;
        logic [7:0] x;
        q.push_back(BOOT_SYNC);
        q.push_back(8'(words.size()));
        x = 8'(words.size());
        foreach (words[k])
            for (int j = 0; j < 4; j++) begin
                q.push_back(words[k][8*j +: 8]);
                x ^= words[k][8*j +: 8];
            end
        q.push_back(x);
        return q;
    endfunction

    // Reference model: parse the image as a byte list, push expected writes,
    // send the bytes up to the first error, then compare the final status.
    task automatic run_image(input bq_t img, input int bad, input string tag);
        int         n = int'(img[1]);
        bit         ok = 1'b1;
        int         last = img.size() - 1;
        logic [7:0] x;
        if (bad == 1 || n == 0 || n > DEPTH) begin
            ok = 1'b0;
            last = 1;
        end else begin
            for (int k = 0; k < n; k++) begin
                if (bad >= 0 && bad <= 2 + 4*k + 3) begin
                    ok = 1'b0;
                    last = bad;
                    break;
                end
                exp_q.push_back('{BASE + 32'(4*k),
                                  {img[5+4*k], img[4+4*k], img[3+4*k], img[2+4*k]}});
            end
            if (ok) begin
                x = img[1];
                for (int i = 2; i < 2 + 4*n; i++) x ^= img[i];
                if (bad == img.size() - 1 || x != img[2 + 4*n]) ok = 1'b0;
            end
        end
        for (int i = 0; i <= last; i++) send_byte(img[i], i != bad);
        repeat (4) @(negedge clk);
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_done"},   {31'd0, done},      {31'd0, ok});
        check({tag, "_err"},    {31'd0, err},       {31'd0, !ok});
        check({tag, "_cpurst"}, {31'd0, cpu_reset}, {31'd0, !ok});
        check({tag, "_busy"},   {31'd0, busy},      32'd0);
    endtask

    initial begin
        bq_t         img;
        logic [31:0] w[$];
        int          kind, n, bad;

        repeat (5) @(negedge clk);
        check_reset_vals("in_reset");
        reset = 1'b1;
        repeat (300) @(negedge clk);
        check_reset_vals("idle");

        img = '{8'hB0, 8'h02, 8'h78, 8'h56, 8'h34, 8'h12,
                8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h28};
        run_image(img, -1, "two_word");
        img[10] = 8'h29;
        run_image(img, -1, "bad_chk");

        run_image('{8'hB0, 8'h00}, -1, "n_zero");
        run_image('{8'hB0, 8'h41}, -1, "n_65");
        run_image('{8'hB0, 8'h01, 8'h44, 8'h33, 8'h22, 8'h11, 8'h45}, -1, "one_word");

        run_image('{8'hB0, 8'h01, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h00}, 4, "stop_low");
        send_byte(8'h55, 1'b1);
        repeat (4) @(negedge clk);
        check("stray_busy", {31'd0, busy}, 32'd0);
        check("stray_err",  {31'd0, err},  32'd1);

        send_byte(8'hB0, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("mid_reset");
        reset = 1'b1;
        repeat (20) @(negedge clk);
        w = '{32'hCAFE_F00D};
        run_image(make_image(w), -1, "after_reset");

        for (int r = 0; r < 8; r++) begin
            kind = int'($urandom_range(0, 3));
            n    = int'($urandom_range(1, 4));
            w.delete();
            for (int k = 0; k < n; k++) w.push_back($urandom);
            img = make_image(w);
            bad = -1;
            if (kind == 1) img[img.size()-1] ^= 8'($urandom_range(1, 255));
            if (kind == 2) bad = int'($urandom_range(1, 2 + 4*n));
            if (kind == 3) img[1] = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(65, 255));
            run_image(img, bad, "rand");
            repeat ($urandom_range(0, 40)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
